// File: rtl/dom_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : dom_pkg                                                          |
// | Purpose : Shared helpers for the DOM-indep GF(2^N) multiplier slice.       |
// |           - rndW()    : width of the fresh-randomness bus for N / SHARES   |
// |           - pairIdx() : row-major index p(i,j) of the unordered share pair |
// |           - default reduction polynomials for GF(4), GF(16), GF(256)       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package dom_pkg;

  localparam logic [2:0] c_POLY_N2 = 3'b111;      // x^2 + x + 1
  localparam logic [4:0] c_POLY_N4 = 5'b10011;    // x^4 + x + 1
  localparam logic [8:0] c_POLY_N8 = 9'h11B;      // x^8 + x^4 + x^3 + x + 1

  // One N-bit random word per unordered share pair.
  function automatic int rndW(input int n, input int shares);
    return n * shares * (shares - 1) / 2;
  endfunction

  // Pairs (lo,hi) with lo<hi enumerated row-major: (0,1),(0,2)...(1,2)...
  // Symmetric, so (i,j) and (j,i) land on the same random word.
  function automatic int pairIdx(input int i, input int j, input int shares);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * shares - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gfn_mul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gfn_mul                                                          |
// | Purpose : Combinational GF(2^N) multiplier, polynomial basis.              |
// |           Carry-less product of A and B reduced modulo POLY.               |
// | Ports   : A [N-1:0] in  - operand A                                        |
// |           B [N-1:0] in  - operand B                                        |
// |           Q [N-1:0] out - A*B mod POLY                                     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module gfn_mul
  import dom_pkg::*;
#(
  parameter int         N    = 2,
  parameter logic [N:0] POLY = c_POLY_N2
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q
);

  logic [2*N-2:0] w_prod;

  always_comb begin
    w_prod = '0;
    // Shift-and-XOR partial products.
    for (int i = 0; i < N; i++) begin
      if (B[i]) begin
        for (int k = 0; k < N; k++) begin
          w_prod[i+k] = w_prod[i+k] ^ A[k];
        end
      end
    end
    // Fold the high terms back down, most significant first.
    for (int k = 2*N-2; k >= N; k--) begin
      if (w_prod[k]) begin
        for (int b = 0; b <= N; b++) begin
          w_prod[k-N+b] = w_prod[k-N+b] ^ POLY[b];
        end
      end
    end
    Q = w_prod[N-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/dom_shared_mul_gfn_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dom_shared_mul_gfn_hs                                            |
// | Purpose : DOM-indep masked multiplier over GF(2^N), any share count, with  |
// |           valid/ready handshake, randomness-valid qualifier and output     |
// |           backpressure. Latency 1+OUT_REG, one result per cycle.           |
// | Ports   : ClkxCI       in  clock                                           |
// |           RstxBI       in  async active-low reset                          |
// |           XxDI, YxDI   in  operand shares, share i at [i*N +: N]           |
// |           ZxDI         in  fresh randomness, one N-bit word per share pair |
// |           InValidxSI   in  X/Y valid                                       |
// |           InReadyxSO   out X/Y/Z accepted this cycle (with both valids)    |
// |           RndValidxSI  in  ZxDI is fresh                                   |
// |           QxDO         out product shares                                  |
// |           OutValidxSO  out QxDO valid                                      |
// |           OutReadyxSI  in  downstream accepts QxDO                         |
// |           RndCntxDO    out fire counter (only with DOM_RND_USAGE_CNT_EN)   |
// | Options : `define DOM_RND_USAGE_CNT_EN adds the 32-bit randomness counter. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module dom_shared_mul_gfn_hs
  import dom_pkg::*;
#(
  parameter int         N       = 2,
  parameter int         SHARES  = 2,
  parameter logic [N:0] POLY    = c_POLY_N2,
  parameter int         OUT_REG = 1
) (
  input  logic                          ClkxCI,
  input  logic                          RstxBI,
  input  logic [N*SHARES-1:0]           XxDI,
  input  logic [N*SHARES-1:0]           YxDI,
  input  logic [rndW(N, SHARES)-1:0]    ZxDI,
  input  logic                          InValidxSI,
  output logic                          InReadyxSO,
  input  logic                          RndValidxSI,
  output logic [N*SHARES-1:0]           QxDO,
  output logic                          OutValidxSO,
  input  logic                          OutReadyxSI
`ifdef DOM_RND_USAGE_CNT_EN
  ,
  output logic [31:0]                   RndCntxDO
`endif
);

  localparam int c_TW = N * SHARES * SHARES;

  logic [c_TW-1:0]       w_term;   // next T[i][j], flat at (i*SHARES+j)*N
  logic [c_TW-1:0]       r_t;      // stage-1 registers
  logic [N*SHARES-1:0]   w_q;      // compressed shares
  logic                  r_v1;
  logic                  w_fire;
  logic                  w_adv1;   // stage 1 hands its content on this cycle

  // Partial products. Cross terms are masked before they reach a register,
  // so no flop ever holds an unmasked x_i*y_j with i != j.
  for (genvar i = 0; i < SHARES; i++) begin : g_row
    for (genvar j = 0; j < SHARES; j++) begin : g_col
      logic [N-1:0] w_prod;

      gfn_mul #(
        .N    (N),
        .POLY (POLY)
      ) u_mul (
        .A (XxDI[i*N +: N]),
        .B (YxDI[j*N +: N]),
        .Q (w_prod)
      );

      if (i == j) begin : g_inner
        assign w_term[(i*SHARES+j)*N +: N] = w_prod;
      end else begin : g_cross
        localparam int c_P = pairIdx(i, j, SHARES);
        assign w_term[(i*SHARES+j)*N +: N] = w_prod ^ ZxDI[c_P*N +: N];
      end
    end
  end

  // Ready does not look at RndValidxSI; only the fire qualifies on it.
  assign InReadyxSO = ~r_v1 | w_adv1;
  assign w_fire     = InValidxSI & RndValidxSI & InReadyxSO;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_t  <= '0;
      r_v1 <= 1'b0;
    end else begin
      if (w_fire) begin
        r_t  <= w_term;
        r_v1 <= 1'b1;
      end else if (w_adv1) begin
        r_v1 <= 1'b0;
      end
    end
  end

  // Domain-wise compression: q_i = XOR_j T[i][j].
  always_comb begin
    w_q = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        w_q[i*N +: N] = w_q[i*N +: N] ^ r_t[(i*SHARES+j)*N +: N];
      end
    end
  end

  if (OUT_REG != 0) begin : g_outReg
    logic                r_v2;
    logic [N*SHARES-1:0] r_q;

    assign w_adv1 = r_v1 & (~r_v2 | OutReadyxSI);

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
        r_q  <= '0;
        r_v2 <= 1'b0;
      end else begin
        if (w_adv1) begin
          r_q  <= w_q;
          r_v2 <= 1'b1;
        end else if (OutReadyxSI) begin
          r_v2 <= 1'b0;
        end
      end
    end

    assign QxDO        = r_q;
    assign OutValidxSO = r_v2;
  end else begin : g_outComb
    // Stage 1 registers drive the output directly; they hold while stalled.
    assign w_adv1      = r_v1 & OutReadyxSI;
    assign QxDO        = w_q;
    assign OutValidxSO = r_v1;
  end

`ifdef DOM_RND_USAGE_CNT_EN
  logic [31:0] r_rndCnt;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_rndCnt <= '0;
    end else if (w_fire) begin
      r_rndCnt <= r_rndCnt + 32'd1;
    end
  end

  assign RndCntxDO = r_rndCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dom_shared_mul_gfn_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dom_shared_mul_gfn_hs                                         |
// | Purpose : Self-checking bench for dom_shared_mul_gfn_hs. Three instances:  |
// |           A: N=2 S=2 OUT_REG=1, B: N=4 S=3 OUT_REG=1,                      |
// |           C: N=8 S=2 OUT_REG=0 (AES polynomial).                           |
// |           Unshared results are checked in order against a GF model queue. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dom_shared_mul_gfn_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstN;

  logic [3:0]  aX, aY, aQ;
  logic [1:0]  aZ;
  logic        aInV, aRndV, aInR, aOutV, aOutR;
  logic [11:0] bX, bY, bQ, bZ;
  logic        bInV, bRndV, bInR, bOutV, bOutR;
  logic [15:0] cX, cY, cQ;
  logic [7:0]  cZ;
  logic        cInV, cRndV, cInR, cOutV, cOutR;
`ifdef DOM_RND_USAGE_CNT_EN
  logic [31:0] aCnt, bCnt, cCnt;
`endif

  dom_shared_mul_gfn_hs #(.N(2), .SHARES(2), .POLY(3'b111), .OUT_REG(1)) dutA (
    .ClkxCI(clk), .RstxBI(rstN), .XxDI(aX), .YxDI(aY), .ZxDI(aZ),
    .InValidxSI(aInV), .InReadyxSO(aInR), .RndValidxSI(aRndV),
    .QxDO(aQ), .OutValidxSO(aOutV), .OutReadyxSI(aOutR)
`ifdef DOM_RND_USAGE_CNT_EN
    , .RndCntxDO(aCnt)
`endif
  );

  dom_shared_mul_gfn_hs #(.N(4), .SHARES(3), .POLY(5'b10011), .OUT_REG(1)) dutB (
    .ClkxCI(clk), .RstxBI(rstN), .XxDI(bX), .YxDI(bY), .ZxDI(bZ),
    .InValidxSI(bInV), .InReadyxSO(bInR), .RndValidxSI(bRndV),
    .QxDO(bQ), .OutValidxSO(bOutV), .OutReadyxSI(bOutR)
`ifdef DOM_RND_USAGE_CNT_EN
    , .RndCntxDO(bCnt)
`endif
  );

  dom_shared_mul_gfn_hs #(.N(8), .SHARES(2), .POLY(9'h11B), .OUT_REG(0)) dutC (
    .ClkxCI(clk), .RstxBI(rstN), .XxDI(cX), .YxDI(cY), .ZxDI(cZ),
    .InValidxSI(cInV), .InReadyxSO(cInR), .RndValidxSI(cRndV),
    .QxDO(cQ), .OutValidxSO(cOutV), .OutReadyxSI(cOutR)
`ifdef DOM_RND_USAGE_CNT_EN
    , .RndCntxDO(cCnt)
`endif
  );

  int DN[3] = '{2, 4, 8};
  int DS[3] = '{2, 3, 2};
  int DP[3] = '{7, 19, 283};

  int checks = 0;
  int errors = 0;
  int popCnt = 0;
  int fireCnt[3] = '{0, 0, 0};
  int expQ[$];

  // Sampled values of the selected instance, taken just before the edge.
  logic        sInR, sOutV, sFire;
  logic [15:0] sQ;

  // Reference GF(2^n) product: multiply-by-x with immediate reduction.
  function automatic int gmul(input int a, input int b, input int n, input int poly);
    int r = 0;
    for (int i = 0; i < n; i++) begin
      if (b[i]) r = r ^ a;
      a = a << 1;
      if (a[n]) a = a ^ poly;
    end
    return r;
  endfunction

  function automatic logic [15:0] mk(input int v, input int n, input int s);
    int acc, sh;
    logic [15:0] r;
    r = '0;
    acc = v & ((1 << n) - 1);
    for (int i = 0; i < s - 1; i++) begin
      sh = int'($urandom) & ((1 << n) - 1);
      r = r | 16'(sh << (i * n));
      acc = acc ^ sh;
    end
    r = r | 16'(acc << ((s - 1) * n));
    return r;
  endfunction

  function automatic int unshare(input logic [15:0] q, input int n, input int s);
    int acc = 0;
    for (int i = 0; i < s; i++) acc = acc ^ (int'(q >> (i * n)) & ((1 << n) - 1));
    return acc;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idleAll();
    aInV = 0; aRndV = 0; aOutR = 1; aX = '0; aY = '0; aZ = '0;
    bInV = 0; bRndV = 0; bOutR = 1; bX = '0; bY = '0; bZ = '0;
    cInV = 0; cRndV = 0; cOutR = 1; cX = '0; cY = '0; cZ = '0;
  endtask

  // One clock cycle on instance d. Entered at posedge+1, leaves at the next posedge+1.
  task automatic cyc(input int d, input bit inV, input bit rndV, input bit outR,
                     input logic [15:0] xs, input logic [15:0] ys, input logic [15:0] zs);
    int exp;
    idleAll();
    case (d)
      0: begin aInV = inV; aRndV = rndV; aOutR = outR; aX = xs[3:0];  aY = ys[3:0];  aZ = zs[1:0];  end
      1: begin bInV = inV; bRndV = rndV; bOutR = outR; bX = xs[11:0]; bY = ys[11:0]; bZ = zs[11:0]; end
      default: begin cInV = inV; cRndV = rndV; cOutR = outR; cX = xs; cY = ys; cZ = zs[7:0]; end
    endcase
    #1;
    case (d)
      0: begin sInR = aInR; sOutV = aOutV; sQ = {12'd0, aQ}; end
      1: begin sInR = bInR; sOutV = bOutV; sQ = {4'd0, bQ}; end
      default: begin sInR = cInR; sOutV = cOutV; sQ = cQ; end
    endcase
    sFire = inV & rndV & sInR;
    if (sOutV && outR) begin
      exp = (expQ.size() > 0) ? expQ.pop_front() : -1;
      chk("result", unshare(sQ, DN[d], DS[d]), exp);
      popCnt++;
    end
    if (sFire) begin
      expQ.push_back(gmul(unshare(xs, DN[d], DS[d]), unshare(ys, DN[d], DS[d]), DN[d], DP[d]));
      fireCnt[d]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int d);
    for (int c = 0; c < 10 && expQ.size() > 0; c++) cyc(d, 0, 0, 1, '0, '0, '0);
    chk("drain empty", expQ.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fed, pops0, z, q0exp;
    logic [15:0] held;
`ifdef DOM_RND_USAGE_CNT_EN
    int cnt0;
`endif
    rstN = 1'b0;
    idleAll();
    #1;
    chk("A rst outValid", aOutV, 0);
    chk("A rst q", aQ, 0);
    chk("B rst outValid", bOutV, 0);
    chk("B rst q", bQ, 0);
    chk("C rst outValid", cOutV, 0);
    chk("C rst q", cQ, 0);
    repeat (2) @(posedge clk);
    #3 rstN = 1'b1;
    @(posedge clk);
    #1;
    chk("A rst inReady", aInR, 1);
    chk("B rst inReady", bInR, 1);
    chk("C rst inReady", cInR, 1);

    // Basic product on A: X=(1,3)=2, Y=(2,1)=3, product 1 for any Z.
    for (int k = 0; k < 3; k++) begin
      z = (k == 0) ? 2 : (k == 1) ? 0 : 3;
      cyc(0, 1, 1, 1, 16'h000D, 16'h0006, 16'(z));
      chk("A basic fire", sFire, 1);
      chk("A basic lat0", sOutV, 0);
      cyc(0, 0, 0, 1, '0, '0, '0);
      chk("A basic lat1", sOutV, 0);
      cyc(0, 0, 0, 1, '0, '0, '0);
      chk("A basic lat2", sOutV, 1);
      chk("A basic product", unshare(sQ, 2, 2), 1);
      q0exp = gmul(1, 2, 2, 7) ^ gmul(1, 1, 2, 7) ^ z;
      chk("A basic share0", int'(sQ[1:0]), q0exp);
    end

    // Randomness gating.
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 0, 1, mk($urandom_range(0, 3), 2, 2), mk($urandom_range(0, 3), 2, 2), 16'($urandom));
      chk("gate fire", sFire, 0);
      chk("gate outValid", sOutV, 0);
      chk("gate inReady", sInR, 1);
    end
    cyc(0, 1, 1, 1, mk($urandom_range(0, 3), 2, 2), mk($urandom_range(0, 3), 2, 2), 16'($urandom));
    chk("gate release fire", sFire, 1);
    cyc(0, 0, 0, 1, '0, '0, '0);
    chk("gate lat1", sOutV, 0);
    cyc(0, 0, 0, 1, '0, '0, '0);
    chk("gate lat2", sOutV, 1);
    cyc(0, 0, 0, 1, '0, '0, '0);
    chk("gate single", sOutV, 0);

    // Backpressure on A.
    fed = 0;
    held = '0;
    for (int c = 0; c < 6; c++) begin
      cyc(0, fed < 4, 1, 0, mk($urandom_range(0, 3), 2, 2), mk($urandom_range(0, 3), 2, 2), 16'($urandom));
      if (sFire) fed++;
      if (c == 3) held = sQ;
    end
    chk("A stall accepted", fed, 2);
    chk("A stall inReady", sInR, 0);
    chk("A stall outValid", sOutV, 1);
    chk("A stall q held", int'(sQ), int'(held));
    pops0 = popCnt;
    for (int c = 0; c < 20 && (fed < 4 || expQ.size() > 0); c++) begin
      cyc(0, fed < 4, 1, 1, mk($urandom_range(0, 3), 2, 2), mk($urandom_range(0, 3), 2, 2), 16'($urandom));
      if (sFire) fed++;
    end
    chk("A release fed", fed, 4);
    chk("A release results", popCnt - pops0, 4);
    chk("A release queue", expQ.size(), 0);

    // Exhaustive GF(16), three shares, full throughput.
    for (int p = 0; p < 256; p++) begin
      cyc(1, 1, 1, 1, mk(p >> 4, 4, 3), mk(p & 15, 4, 3), 16'($urandom));
      chk("B throughput", sInR, 1);
    end
    drain(1);

    // Reset while results are in flight.
    cyc(1, 1, 1, 0, mk(5, 4, 3), mk(9, 4, 3), 16'($urandom));
    cyc(1, 1, 1, 0, mk(7, 4, 3), mk(3, 4, 3), 16'($urandom));
    cyc(1, 0, 0, 0, '0, '0, '0);
    chk("B pre-reset outValid", sOutV, 1);
    #3 rstN = 1'b0;
    #1;
    chk("B async rst outValid", bOutV, 0);
    chk("B async rst q", bQ, 0);
    expQ.delete();
    fireCnt = '{0, 0, 0};
    @(posedge clk);
    #3 rstN = 1'b1;
    @(posedge clk);
    #1;
`ifdef DOM_RND_USAGE_CNT_EN
    chk("C cnt reset", int'(cCnt), 0);
`endif
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 1, '0, '0, '0);
      chk("B post-reset inReady", sInR, 1);
      chk("B no stale output", sOutV, 0);
    end

    // GF(256), combinational compression.
`ifdef DOM_RND_USAGE_CNT_EN
    cnt0 = int'(cCnt);
`endif
    cyc(2, 1, 1, 1, mk(8'h57, 8, 2), mk(8'h83, 8, 2), 16'($urandom));
    chk("C fire", sFire, 1);
    cyc(2, 0, 0, 1, '0, '0, '0);
    chk("C lat1", sOutV, 1);
    chk("C product", unshare(sQ, 8, 2), 8'hC1);
`ifdef DOM_RND_USAGE_CNT_EN
    chk("C cnt step", int'(cCnt) - cnt0, 1);
`endif
    for (int k = 0; k < 60; k++) begin
      cyc(2, ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
          mk($urandom_range(0, 255), 8, 2), mk($urandom_range(0, 255), 8, 2), 16'($urandom));
    end
    drain(2);
`ifdef DOM_RND_USAGE_CNT_EN
    chk("C cnt total", int'(cCnt), fireCnt[2]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
